// File: rtl/membus_arb2.sv
// Two-master arbiter for one memory bus port: grants a whole memory cycle (including
// read-modify-write) to one master and steers requests, data and strobes accordingly.
module membus_arb2 #(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         m0_rq_cyc,
    input  logic         m0_rd_rq,
    input  logic         m0_wr_rq,
    input  logic         m0_wr_rs,
    input  logic [18:35] m0_ma,
    input  logic         m0_fmc_select,
    input  logic [0:35]  m0_mb_out,
    output logic         m0_addr_ack,
    output logic         m0_rd_rs,
    output logic [0:35]  m0_mb_in,
    output logic         m0_nxm,

    input  logic         m1_rq_cyc,
    input  logic         m1_rd_rq,
    input  logic         m1_wr_rq,
    input  logic         m1_wr_rs,
    input  logic [18:35] m1_ma,
    input  logic         m1_fmc_select,
    input  logic [0:35]  m1_mb_out,
    output logic         m1_addr_ack,
    output logic         m1_rd_rs,
    output logic [0:35]  m1_mb_in,
    output logic         m1_nxm,

    output logic         membus_rq_cyc,
    output logic         membus_rd_rq,
    output logic         membus_wr_rq,
    output logic         membus_wr_rs,
    output logic         membus_fmc_select,
    output logic [18:35] membus_ma,
    output logic [0:35]  membus_mb_out,
    input  logic         membus_addr_ack,
    input  logic         membus_rd_rs,
    input  logic [0:35]  membus_mb_in
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        rd_seen_q, rd_seen_d;
    logic        nxm_q, nxm_d;

    logic         g_rq_cyc, g_rd_rq, g_wr_rq, g_wr_rs, g_fmc_select;
    logic [18:35] g_ma;
    logic [0:35]  g_mb_out;
    logic         busy, in_addr, in_data, done;

    // Granted master's request lines; gated below by registered state only.
    always_comb begin
        g_rq_cyc     = gnt_q ? m1_rq_cyc     : m0_rq_cyc;
        g_rd_rq      = gnt_q ? m1_rd_rq      : m0_rd_rq;
        g_wr_rq      = gnt_q ? m1_wr_rq      : m0_wr_rq;
        g_wr_rs      = gnt_q ? m1_wr_rs      : m0_wr_rs;
        g_fmc_select = gnt_q ? m1_fmc_select : m0_fmc_select;
        g_ma         = gnt_q ? m1_ma         : m0_ma;
        g_mb_out     = gnt_q ? m1_mb_out     : m0_mb_out;
    end

    assign busy    = (state_q != StIdle);
    assign in_addr = (state_q == StAddr);
    assign in_data = (state_q == StData);

    always_comb begin
        membus_rq_cyc     = busy & g_rq_cyc;
        membus_rd_rq      = busy & g_rd_rq;
        membus_wr_rq      = busy & g_wr_rq;
        membus_fmc_select = busy & g_fmc_select;
        membus_ma         = busy ? g_ma : '0;
        membus_mb_out     = busy ? g_mb_out : '0;
        membus_wr_rs      = in_data & g_wr_rs;

        m0_addr_ack = in_addr & ~gnt_q & membus_addr_ack;
        m1_addr_ack = in_addr &  gnt_q & membus_addr_ack;
        m0_rd_rs    = in_data & ~gnt_q & membus_rd_rs;
        m1_rd_rs    = in_data &  gnt_q & membus_rd_rs;
        m0_mb_in    = (busy & ~gnt_q) ? membus_mb_in : '0;
        m1_mb_in    = (busy &  gnt_q) ? membus_mb_in : '0;
        m0_nxm      = nxm_q & ~gnt_q;
        m1_nxm      = nxm_q &  gnt_q;
    end

    // RMW needs the read restart strictly before the write restart.
    assign done = wr_q ? (g_wr_rs & (~rd_q | rd_seen_q)) : membus_rd_rs;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        rd_seen_d = rd_seen_q;
        nxm_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_rq_cyc | m1_rq_cyc) begin
                    state_d = StAddr;
                    cnt_d   = '0;
                    if (m0_rq_cyc & m1_rq_cyc) begin
                        gnt_d = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
                    end else begin
                        gnt_d = m1_rq_cyc;
                    end
                end
            end
            StAddr: begin
                if (membus_addr_ack) begin
                    state_d   = StData;
                    rd_d      = g_rd_rq;
                    wr_d      = g_wr_rq;
                    rd_seen_d = 1'b0;
                end else if (!g_rq_cyc) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                    nxm_d   = 1'b1;
                    last_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (membus_rd_rs) begin
                    rd_seen_d = 1'b1;
                end
                if (done) begin
                    state_d = StIdle;
                    last_d  = gnt_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_seen_q <= 1'b0;
            nxm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rd_seen_q <= rd_seen_d;
            nxm_q     <= nxm_d;
        end
    end

endmodule

// File: tb/tb_membus_arb2.sv
// Random-stimulus bench for membus_arb2: a round-robin instance and a fixed-priority
// instance share inputs and are checked every cycle against a cycle-ownership model.
module tb_membus_arb2;

    logic clk;
    logic reset;

    logic [1:0]       rq_cyc, rd_rq, wr_rq, wr_rs, fmc;
    logic [1:0][17:0] ma;
    logic [1:0][35:0] mb_out;
    logic             mem_ack, mem_rd_rs;
    logic [35:0]      mem_mb_in;

    wire [1:0][1:0]       addr_ack_o, rd_rs_o, nxm_o;
    wire [1:0][1:0][35:0] mb_in_o;
    wire [1:0]            bus_rq_cyc, bus_rd_rq, bus_wr_rq, bus_wr_rs, bus_fmc;
    wire [1:0][17:0]      bus_ma;
    wire [1:0][35:0]      bus_mb_out;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        membus_arb2 #(
            .FIXED_PRIO(k),
            .TIMEOUT   (k == 0 ? 8 : 5)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .m0_rq_cyc        (rq_cyc[0]),
            .m0_rd_rq         (rd_rq[0]),
            .m0_wr_rq         (wr_rq[0]),
            .m0_wr_rs         (wr_rs[0]),
            .m0_ma            (ma[0]),
            .m0_fmc_select    (fmc[0]),
            .m0_mb_out        (mb_out[0]),
            .m0_addr_ack      (addr_ack_o[k][0]),
            .m0_rd_rs         (rd_rs_o[k][0]),
            .m0_mb_in         (mb_in_o[k][0]),
            .m0_nxm           (nxm_o[k][0]),
            .m1_rq_cyc        (rq_cyc[1]),
            .m1_rd_rq         (rd_rq[1]),
            .m1_wr_rq         (wr_rq[1]),
            .m1_wr_rs         (wr_rs[1]),
            .m1_ma            (ma[1]),
            .m1_fmc_select    (fmc[1]),
            .m1_mb_out        (mb_out[1]),
            .m1_addr_ack      (addr_ack_o[k][1]),
            .m1_rd_rs         (rd_rs_o[k][1]),
            .m1_mb_in         (mb_in_o[k][1]),
            .m1_nxm           (nxm_o[k][1]),
            .membus_rq_cyc    (bus_rq_cyc[k]),
            .membus_rd_rq     (bus_rd_rq[k]),
            .membus_wr_rq     (bus_wr_rq[k]),
            .membus_wr_rs     (bus_wr_rs[k]),
            .membus_fmc_select(bus_fmc[k]),
            .membus_ma        (bus_ma[k]),
            .membus_mb_out    (bus_mb_out[k]),
            .membus_addr_ack  (mem_ack),
            .membus_rd_rs     (mem_rd_rs),
            .membus_mb_in     (mem_mb_in)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: who owns the bus and in which phase of its cycle it is.
    // phase 0 = free, 1 = waiting for address ack, 2 = waiting for completion.
    int  tmo[2]   = '{8, 5};
    int  fixed[2] = '{0, 1};
    int  phase[2], owner[2], last_srv[2], waited[2];
    bit  want_rd[2], want_wr[2], read_back[2], nxm_now[2];
    int  n_nxm, n_done;

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit finished;
            int o;
            finished   = 1'b0;
            o          = owner[k];
            nxm_now[k] = 1'b0;
            if (reset) begin
                phase[k] = 0; owner[k] = 0; last_srv[k] = 1; waited[k] = 0;
                read_back[k] = 1'b0;
            end else if (phase[k] == 0) begin
                if (rq_cyc == 2'b11) begin
                    owner[k] = (fixed[k] != 0) ? 0 : 1 - last_srv[k];
                end else if (rq_cyc != 2'b00) begin
                    owner[k] = rq_cyc[1] ? 1 : 0;
                end
                if (rq_cyc != 2'b00) begin
                    phase[k]  = 1;
                    waited[k] = 0;
                end
            end else if (phase[k] == 1) begin
                if (mem_ack) begin
                    phase[k] = 2; want_rd[k] = rd_rq[o]; want_wr[k] = wr_rq[o];
                    read_back[k] = 1'b0;
                end else if (!rq_cyc[o]) begin
                    phase[k] = 0;
                end else if (waited[k] + 1 >= tmo[k]) begin
                    phase[k] = 0; nxm_now[k] = 1'b1; last_srv[k] = o; n_nxm++;
                end else begin
                    waited[k]++;
                end
            end else begin
                if (!want_wr[k])      finished = mem_rd_rs;
                else if (!want_rd[k]) finished = wr_rs[o];
                else                  finished = wr_rs[o] && read_back[k];
                if (mem_rd_rs) read_back[k] = 1'b1;
                if (finished) begin
                    phase[k] = 0; last_srv[k] = o; n_done++;
                end
            end
        end
    endtask

    task automatic compare(input int cyc);
        for (int k = 0; k < 2; k++) begin
            int o;
            bit on;
            logic [63:0] exp_bus, got_bus;
            o  = owner[k];
            on = (phase[k] != 0);
            exp_bus = '0;
            if (on) exp_bus = {5'd0, rq_cyc[o], rd_rq[o], wr_rq[o], (phase[k] == 2) & wr_rs[o],
                               fmc[o], ma[o], mb_out[o]};
            got_bus = {5'd0, bus_rq_cyc[k], bus_rd_rq[k], bus_wr_rq[k], bus_wr_rs[k], bus_fmc[k],
                       bus_ma[k], bus_mb_out[k]};
            check_eq($sformatf("bus k%0d c%0d", k, cyc), got_bus, exp_bus);
            for (int m = 0; m < 2; m++) begin
                bit mine;
                logic [63:0] exp_m, got_m;
                mine  = on && (o == m);
                exp_m = {25'd0, (mine && phase[k] == 1) ? mem_ack : 1'b0,
                         (mine && phase[k] == 2) ? mem_rd_rs : 1'b0,
                         nxm_now[k] && (o == m), mine ? mem_mb_in : 36'd0};
                got_m = {25'd0, addr_ack_o[k][m], rd_rs_o[k][m], nxm_o[k][m], mb_in_o[k][m]};
                check_eq($sformatf("m%0d k%0d c%0d", m, k, cyc), got_m, exp_m);
            end
        end
    endtask

    int ack_pct;

    task automatic drive(input int cyc);
        if (cyc % 256 == 0) begin
            case ($urandom_range(0, 2))
                0:       ack_pct = 0;
                1:       ack_pct = 20;
                default: ack_pct = 60;
            endcase
            if (cyc == 0) ack_pct = 40;
        end
        reset = (cyc < 3) || ($urandom_range(0, 199) == 0);
        for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 99) < 12) rq_cyc[m] = ~rq_cyc[m];
            rd_rq[m]  = 1'($urandom);
            wr_rq[m]  = 1'($urandom);
            wr_rs[m]  = ($urandom_range(0, 99) < 20);
            fmc[m]    = 1'($urandom);
            ma[m]     = 18'($urandom);
            mb_out[m] = {4'($urandom), $urandom};
        end
        mem_ack   = ($urandom_range(0, 99) < ack_pct);
        mem_rd_rs = ($urandom_range(0, 99) < 20);
        mem_mb_in = {4'($urandom), $urandom};
    endtask

    initial begin
        reset = 1'b1;
        rq_cyc = '0; rd_rq = '0; wr_rq = '0; wr_rs = '0; fmc = '0;
        ma = '0; mb_out = '0;
        mem_ack = 1'b0; mem_rd_rs = 1'b0; mem_mb_in = '0;
        n_nxm = 0; n_done = 0; ack_pct = 40;
        for (int k = 0; k < 2; k++) begin
            phase[k] = 0; owner[k] = 0; last_srv[k] = 1; waited[k] = 0;
            want_rd[k] = 1'b0; want_wr[k] = 1'b0; read_back[k] = 1'b0; nxm_now[k] = 1'b0;
        end
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            model_step();
            #1;
            drive(i);
            #1;
            compare(i);
        end
        $display("model saw %0d completions and %0d timeouts", n_done, n_nxm);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
